// File: rtl/swipt_data_receiver.sv
// SWIPT receive path: slices the ADC load current against the running mean, recovers bit timing and
// deserializes one 26-bit answer frame. Define CHECKSUM_VERIFY_EN to require payload + checksum == 8'hFF.
module swipt_data_receiver #(
    parameter int          BIT_PERIOD = 200000,
    parameter logic [11:0] THRESH     = 12'd16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    input  logic        data_start,
    input  logic        readDataIn,
    input  logic [11:0] ADC,
    input  logic [11:0] mean_def,
    output logic        din,
    output logic        dataInReady,
    output logic [7:0]  dataIn,
    output logic [7:0]  sumChecker,
    output logic        frame_err
);

    localparam int               CNT_W     = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_PERIOD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HUNT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_CHECK  = 2'd3;

    localparam logic [5:0] PREAMBLE = 6'b101010;
    localparam logic [3:0] TRAILER  = 4'b0101;

    logic [1:0]       state;
    logic             din_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [4:0]       bit_idx;
    logic [25:0]      shift_reg;

    logic        clear;
    logic        slice_hi;
    logic [25:0] shift_next;
    logic        sum_ok;
    logic        frame_ok;

    assign clear      = ~nrst | ~swiptAlive | ~data_start;
    // 13-bit compare so mean_def + THRESH can never wrap
    assign slice_hi   = ({1'b0, ADC} > ({1'b0, mean_def} + {1'b0, THRESH}));
    assign shift_next = {shift_reg[24:0], din};

`ifdef CHECKSUM_VERIFY_EN
    logic [7:0] csum_total;
    assign csum_total = shift_next[19:12] + shift_next[11:4];
    assign sum_ok     = (csum_total == 8'hFF);
`else
    assign sum_ok     = 1'b1;
`endif

    assign frame_ok = (shift_next[25:20] == PREAMBLE) && (shift_next[3:0] == TRAILER) && sum_ok;

    // NOTE: all state uses non-blocking assignments; the clear term is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= S_IDLE;
            din         <= 1'b0;
            din_prev    <= 1'b0;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            dataInReady <= 1'b0;
            frame_err   <= 1'b0;
            dataIn      <= '0;
            sumChecker  <= '0;
        end else begin
            din         <= readDataIn & slice_hi;
            din_prev    <= din;
            dataInReady <= 1'b0;
            frame_err   <= 1'b0;

            if (!readDataIn) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: state <= S_HUNT;

                    S_HUNT: begin
                        if (din && !din_prev) begin
                            bit_cnt <= HALF_LOAD;
                            bit_idx <= '0;
                            state   <= S_SAMPLE;
                        end
                    end

                    S_SAMPLE: begin
                        if (bit_cnt == '0) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= FULL_LOAD;
                            bit_idx   <= bit_idx + 5'd1;
                            if (bit_idx == 5'd5 && shift_next[5:0] != PREAMBLE) begin
                                state <= S_HUNT;
                            end else if (bit_idx == 5'd25) begin
                                // Verdict is registered on the last sample so the pulse is visible during CHECK
                                state <= S_CHECK;
                                if (frame_ok) begin
                                    dataIn      <= shift_next[19:12];
                                    sumChecker  <= shift_next[11:4];
                                    dataInReady <= 1'b1;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end

                    S_CHECK: state <= S_HUNT;

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_swipt_data_receiver.sv
// Self-checking bench for swipt_data_receiver: directed frames plus randomized line streams checked
// against a bit-slot-level frame decoder model.
`timescale 1ns/1ps
module tb_swipt_data_receiver;

    localparam int          BP   = 8;
    localparam logic [11:0] MEAN = 12'h400;
    localparam logic [11:0] TH   = 12'd16;
    localparam logic [16:0] EV_ERR = 17'h10000;

    logic        clk = 1'b0;
    logic        nrst, swiptAlive, data_start, readDataIn;
    logic [11:0] ADC, mean_def;
    logic        din, dataInReady, frame_err;
    logic [7:0]  dataIn, sumChecker;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          last_pulse_cyc = 0;
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [7:0]  exp_data = 8'h00;
    logic [7:0]  exp_sum  = 8'h00;
    logic        prev_ready = 1'b0;
    logic        prev_err   = 1'b0;
    bit          rand_levels = 1'b0;
    bit          stream[$];

    swipt_data_receiver #(.BIT_PERIOD(BP), .THRESH(TH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .swiptAlive (swiptAlive),
        .data_start (data_start),
        .readDataIn (readDataIn),
        .ADC        (ADC),
        .mean_def   (mean_def),
        .din        (din),
        .dataInReady(dataInReady),
        .dataIn     (dataIn),
        .sumChecker (sumChecker),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: records every reported frame and checks pulse shape
    always @(negedge clk) begin
        if (dataInReady === 1'b1) begin
            obs_q.push_back({1'b0, dataIn, sumChecker});
            last_pulse_cyc = cyc;
            check("ready_width", 32'(prev_ready), 32'd0);
            check("ready_err_excl", 32'(frame_err), 32'd0);
        end
        if (frame_err === 1'b1) begin
            obs_q.push_back(EV_ERR);
            last_pulse_cyc = cyc;
            check("err_width", 32'(prev_err), 32'd0);
        end
        prev_ready <= dataInReady;
        prev_err   <= frame_err;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] line_adc(input bit b);
        int lo;
        lo = int'(MEAN) + int'(TH) + 1;
        if (!rand_levels) return b ? 12'h500 : 12'h300;
        return b ? 12'($urandom_range(4095, lo)) : 12'($urandom_range(lo - 1, 0));
    endfunction

    task automatic drive_bit(input bit b);
        for (int c = 0; c < BP; c++) begin
            ADC = line_adc(b);
            tick();
        end
    endtask

    task automatic push_frame(input logic [5:0] pre, input logic [7:0] pl, input logic [7:0] cs,
                              input logic [3:0] tr);
        logic [25:0] f;
        f = {pre, pl, cs, tr};
        for (int i = 25; i >= 0; i--) stream.push_back(f[i]);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) stream.push_back(1'b0);
    endtask

    function automatic int field(input int start, input int len);
        int v;
        v = 0;
        for (int k = 0; k < len; k++) v = v * 2 + int'(stream[start + k]);
        return v;
    endfunction

    // Bit-slot model: a 0->1 slot boundary starts a frame; a bad preamble resumes the hunt after
    // six slots, a complete frame resumes after 26 slots.
    task automatic model_stream();
        int  i, pl, cs, tr;
        bit  ok;
        i = 0;
        while (i < stream.size()) begin
            if (stream[i] && (i == 0 || !stream[i-1]) && (i + 26 <= stream.size())) begin
                if (field(i, 6) != 42) begin
                    i += 6;
                end else begin
                    pl = field(i + 6, 8);
                    cs = field(i + 14, 8);
                    tr = field(i + 22, 4);
                    ok = (tr == 5);
`ifdef CHECKSUM_VERIFY_EN
                    ok = ok && (((pl + cs) % 256) == 255);
`endif
                    if (ok) begin
                        exp_q.push_back({1'b0, 8'(pl), 8'(cs)});
                        exp_data = 8'(pl);
                        exp_sum  = 8'(cs);
                    end else begin
                        exp_q.push_back(EV_ERR);
                    end
                    i += 26;
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic run_stream(input string tag);
        push_idle(30);
        model_stream();
        start_cyc = cyc;
        for (int i = 0; i < stream.size(); i++) drive_bit(stream[i]);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_event"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
        stream.delete();
        check({tag, "_dataIn"}, 32'(dataIn), 32'(exp_data));
        check({tag, "_sumChecker"}, 32'(sumChecker), 32'(exp_sum));
    endtask

    initial begin
        logic [25:0] f;
        logic [7:0]  pl;
        int          kind;

        nrst = 1'b0; swiptAlive = 1'b1; data_start = 1'b1; readDataIn = 1'b1;
        ADC = 12'h500; mean_def = MEAN;
        repeat (3) tick();
        check("rst_din", 32'(din), 32'd0);
        check("rst_ready", 32'(dataInReady), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_dataIn", 32'(dataIn), 32'd0);
        check("rst_sum", 32'(sumChecker), 32'd0);

        nrst = 1'b1; ADC = 12'h000;
        repeat (3) tick();

        ADC = 12'h410; tick();
        check("slice_equal", 32'(din), 32'd0);
        ADC = 12'h411; tick();
        check("slice_above", 32'(din), 32'd1);
        readDataIn = 1'b0; tick();
        check("slice_rd_low", 32'(din), 32'd0);
        ADC = 12'h000; readDataIn = 1'b1;
        repeat (4) tick();

        push_frame(6'b101010, 8'hA5, 8'h5A, 4'b0101);
        run_stream("frame_a5");
        check("a5_dataIn", 32'(dataIn), 32'hA5);
        check("a5_latency", 32'(last_pulse_cyc - start_cyc), 32'(2 + BP / 2 + 25 * BP));

        push_frame(6'b101110, 8'h00, 8'h00, 4'b0000);
        push_idle(4);
        push_frame(6'b101010, 8'h3C, 8'hC3, 4'b0101);
        run_stream("bad_preamble");
        check("3c_dataIn", 32'(dataIn), 32'h3C);

        push_frame(6'b101010, 8'h11, 8'hEE, 4'b0111);
        run_stream("bad_trailer");

        push_frame(6'b101010, 8'hA5, 8'h00, 4'b0101);
        run_stream("checksum");

        // Drop data_start partway through a frame
        f = {6'b101010, 8'h66, 8'h99, 4'b0101};
        for (int i = 25; i > 13; i--) drive_bit(f[i]);
        data_start = 1'b0; tick();
        check("clr_din", 32'(din), 32'd0);
        check("clr_ready", 32'(dataInReady), 32'd0);
        check("clr_err", 32'(frame_err), 32'd0);
        check("clr_dataIn", 32'(dataIn), 32'd0);
        check("clr_sum", 32'(sumChecker), 32'd0);
        ADC = 12'h000;
        repeat (3) tick();
        data_start = 1'b1;
        exp_data = 8'h00; exp_sum = 8'h00;
        repeat (3) tick();
        push_frame(6'b101010, 8'h81, 8'h7E, 4'b0101);
        run_stream("after_clear");
        check("81_dataIn", 32'(dataIn), 32'h81);

        swiptAlive = 1'b0; ADC = 12'h500; tick();
        check("alive_low_din", 32'(din), 32'd0);
        check("alive_low_dataIn", 32'(dataIn), 32'd0);
        swiptAlive = 1'b1; ADC = 12'h000;
        exp_data = 8'h00; exp_sum = 8'h00;
        repeat (3) tick();

        rand_levels = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 10; s++) begin
                kind = int'($urandom_range(4, 0));
                pl = 8'($urandom);
                case (kind)
                    0: push_frame(6'b101010, pl, ~pl, 4'b0101);
                    1: push_frame(6'b101010, pl, 8'($urandom), 4'b0101);
                    2: push_frame(6'b101010, pl, ~pl, 4'($urandom));
                    3: push_frame(6'($urandom), pl, 8'($urandom), 4'($urandom));
                    default: push_idle(int'($urandom_range(8, 1)));
                endcase
                push_idle(int'($urandom_range(4, 1)));
            end
            run_stream("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/swipt_data_receiver.md
# swipt_data_receiver

Receive path of the SWIPT data link. Slices the sampled load-current ADC stream against the running mean into a binary line signal, recovers bit timing, deserializes one answer frame, and presents the payload byte and checksum byte with a one-cycle ready pulse. Sits beside the transmit/control FSM, which raises `readDataIn` while it waits for an answer.

## Interface
- `BIT_PERIOD`, 200000: clocks per bit; must be even and at least 4.
- `THRESH`, 12'd16: slicer margin above `mean_def`.
- `clk` in 1: clock.
- `nrst` in 1: reset, synchronous, active-low.
- `swiptAlive` in 1: link alive. Low clears like reset.
- `data_start` in 1: data phase enabled. Low clears like reset.
- `readDataIn` in 1: receive window from the control FSM.
- `ADC` in 12: current sample, unsigned.
- `mean_def` in 12: mean current, unsigned.
- `din` out 1: registered slicer output.
- `dataInReady` out 1: one-cycle pulse when a valid frame is received.
- `dataIn` out 8: received payload byte.
- `sumChecker` out 8: received checksum byte.
- `frame_err` out 1: one-cycle pulse when a frame fails its trailer check, or its checksum check when checksum checking is compiled in.

## Operation
- **Clear condition:** `~nrst | ~swiptAlive | ~data_start`, evaluated synchronously. While it holds:
  - all outputs are 0.
  - the FSM is in IDLE.
  - counters and the shift register are 0.
- **Slicer:**
  - `din <= readDataIn & ({1'b0,ADC} > {1'b0,mean_def} + THRESH)`.
  - The comparison uses 13-bit unsigned arithmetic and is strict, so no overflow wrap is possible.
- **Frame format:** 26 bits, MSB first.
  - 6'b101010 preamble
  - 8-bit payload
  - 8-bit checksum
  - 4'b0101 trailer
- **FSM states and transitions:**
  - IDLE: go to HUNT when `readDataIn`=1.
  - HUNT: wait for a rising edge of `din` (`din`=1 and the previous `din`=0). On the edge, load the bit counter with BIT_PERIOD/2−1, clear the bit index, and go to SAMPLE.
  - SAMPLE: decrement the counter. At 0:
    - shift `din` into a 26-bit register;
    - reload the counter with BIT_PERIOD−1;
    - increment the bit index.
  - SAMPLE, after the 6th bit: if the low 6 bits ≠ 101010, go to HUNT with no error pulse.
  - SAMPLE, after the 26th bit: go to CHECK.
  - CHECK, one cycle:
    - If trailer = 0101, and the checksum passes (see Configuration): latch `dataIn` and `sumChecker`, pulse `dataInReady`.
    - Otherwise: pulse `frame_err`; `dataIn` and `sumChecker` are unchanged.
    - Then go to HUNT.
- **`readDataIn`=0 in any state:** return to IDLE the next cycle. `dataIn` and `sumChecker` hold their values; the pulses are 0.
- **Simultaneous events:** the clear condition has priority over `readDataIn`; `readDataIn` has priority over FSM progress.

## Timing
- `din` lags `ADC` by 1 cycle.
- The first sample is taken BIT_PERIOD/2 cycles after the edge-detect cycle. Each later sample follows the previous one by BIT_PERIOD cycles.
- `dataInReady` and `frame_err` assert the cycle after the 26th sample and are high for exactly 1 cycle.
- `dataIn` and `sumChecker` update in the same cycle that `dataInReady` rises and are stable from then on.
- A new frame can be hunted on the cycle after CHECK.
- Clearing mid-frame takes effect on the next clock edge; no partial frame is ever reported.

## Configuration
- `CHECKSUM_VERIFY_EN`:
  - Defined: the frame is valid only if the trailer is correct and `payload + checksum == 8'hFF` (mod 256). A checksum failure pulses `frame_err` and does not pulse `dataInReady`.
  - Undefined: the checksum is not checked; it is passed through on `sumChecker`, and a valid trailer alone gives `dataInReady`.

## Test plan
Common setup: BIT_PERIOD=8, THRESH=16, `mean_def`=0x400; a line "1" is driven as `ADC`=0x500 and a line "0" as `ADC`=0x300.
- Frame with payload 0xA5, checksum 0x5A, correct preamble and trailer -> one `dataInReady` pulse, `dataIn`=0xA5, `sumChecker`=0x5A, `frame_err`=0.
- Preamble sent as 101110 -> no `dataInReady`, no `frame_err`; a following correct frame with payload 0x3C, checksum 0xC3 is received, `dataIn`=0x3C.
- Trailer 0111 -> `frame_err` pulses once; `dataIn` keeps its previous value.
- With `CHECKSUM_VERIFY_EN`: payload 0xA5, checksum 0x00 -> `frame_err` pulse, no `dataInReady`. Without the macro: `dataInReady` pulses and `sumChecker`=0x00.
- `ADC`=0x410 (exactly `mean_def`+THRESH) -> `din`=0; `ADC`=0x411 -> `din`=1 one cycle later; `readDataIn`=0 -> `din`=0.
- `data_start` dropped at bit 12 -> all outputs are 0 on the next cycle; after `data_start` is restored, a full frame with payload 0x81 is received correctly.
